// File: rtl/conv_seq_ctrl_if.sv
// Handshake/bus bundle between the Conv sequencer and its neighbours:
// frame input, Conv window/launch, Conv results and the downstream result port.
interface conv_seq_ctrl_if #(
  parameter int NCH  = 8,
  parameter int WIN  = 5,
  parameter int NOUT = 3,
  parameter int DW   = 16,
  parameter int OW   = 24
);
  logic          i_clear;
  logic [DW-1:0] i_frame [0:NCH-1];
  logic          i_frame_valid;
  logic          o_frame_ready;
  logic [DW-1:0] o_conv_data [0:NCH*WIN-1];
  logic          o_conv_start;
  logic [OW-1:0] i_conv_out [0:NOUT-1];
  logic [OW-1:0] o_result [0:NOUT-1];
  logic          o_result_valid;
  logic          i_result_ready;
  logic          o_busy;

  modport slave (
    input  i_clear, i_frame, i_frame_valid, i_conv_out, i_result_ready,
    output o_frame_ready, o_conv_data, o_conv_start, o_result, o_result_valid, o_busy
  );

  modport master (
    output i_clear, i_frame, i_frame_valid, i_conv_out, i_result_ready,
    input  o_frame_ready, o_conv_data, o_conv_start, o_result, o_result_valid, o_busy
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Conv sequencer: sliding window of WIN frames per channel, strided launches,
// fixed-latency capture of Conv results and a valid/ready result port.
module conv_seq_lane #(
  parameter int WIN = 5,
  parameter int DW  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_shift,
  input  logic [DW-1:0] i_sample,
  output logic [DW-1:0] o_win [0:WIN-1]
);
  logic [DW-1:0] win_q [0:WIN-1];

  // Slot 0 holds the oldest sample; new samples enter at WIN-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < WIN; t++) win_q[t] <= '0;
    end else if (i_clear) begin
      for (int t = 0; t < WIN; t++) win_q[t] <= '0;
    end else if (i_shift) begin
      for (int t = 0; t < WIN-1; t++) win_q[t] <= win_q[t+1];
      win_q[WIN-1] <= i_sample;
    end
  end

  assign o_win = win_q;
endmodule

module conv_seq_ctrl #(
  parameter int NCH      = 8,
  parameter int WIN      = 5,
  parameter int NOUT     = 3,
  parameter int DW       = 16,
  parameter int OW       = 24,
  parameter int STRIDE   = 1,
  parameter int CONV_LAT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  conv_seq_ctrl_if.slave  bus
);
  localparam int FW = $clog2(WIN + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [1:0] {FILL, RUN, OUT} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [SW-1:0] stride_q, stride_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          launched_q, launched_d;
  logic          start_q, start_d;
  logic [OW-1:0] res_q [0:NOUT-1];
  logic [OW-1:0] res_d [0:NOUT-1];
  logic          accept;
  logic          launch;
  logic [DW-1:0] lane_win [0:NCH-1][0:WIN-1];

  genvar ch, t;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_lane
      conv_seq_lane #(.WIN(WIN), .DW(DW)) u_lane (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (bus.i_clear),
        .i_shift  (accept),
        .i_sample (bus.i_frame[ch]),
        .o_win    (lane_win[ch])
      );
      // Channel-major layout expected by Conv: element ch*WIN+t.
      for (t = 0; t < WIN; t++) begin : g_tap
        assign bus.o_conv_data[ch*WIN+t] = lane_win[ch][t];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= FILL;
      fill_q     <= '0;
      stride_q   <= '0;
      lat_q      <= '0;
      launched_q <= 1'b0;
      start_q    <= 1'b0;
      for (int o = 0; o < NOUT; o++) res_q[o] <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      stride_q   <= stride_d;
      lat_q      <= lat_d;
      launched_q <= launched_d;
      start_q    <= start_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    stride_d   = stride_q;
    lat_d      = lat_q;
    launched_d = launched_q;
    start_d    = 1'b0;
    res_d      = res_q;
    accept     = 1'b0;
    launch     = 1'b0;

    if (bus.i_clear) begin
      state_d    = FILL;
      fill_d     = '0;
      stride_d   = '0;
      lat_d      = '0;
      launched_d = 1'b0;
      res_d      = '{default: '0};
    end else begin
      unique case (state_q)
        FILL: begin
          if (bus.i_frame_valid) begin
            accept = 1'b1;
            if (fill_q != FW'(WIN)) fill_d = fill_q + FW'(1);
            // The very first full window launches at once; afterwards every STRIDE accepts.
            if (fill_d == FW'(WIN) && !launched_q) begin
              launch = 1'b1;
            end else if (fill_q == FW'(WIN)) begin
              if (stride_q == SW'(STRIDE-1)) begin
                launch   = 1'b1;
                stride_d = '0;
              end else begin
                stride_d = stride_q + SW'(1);
              end
            end
            if (launch) begin
              state_d    = RUN;
              lat_d      = '0;
              start_d    = 1'b1;
              launched_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (lat_q == LW'(CONV_LAT-1)) begin
            res_d   = bus.i_conv_out;
            lat_d   = '0;
            state_d = OUT;
          end else begin
            lat_d = lat_q + LW'(1);
          end
        end
        OUT: begin
          if (bus.i_result_ready) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign bus.o_frame_ready  = (state_q == FILL);
  assign bus.o_conv_start   = start_q;
  assign bus.o_result       = res_q;
  assign bus.o_result_valid = (state_q == OUT);
  assign bus.o_busy         = (state_q != FILL);
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized self-checking bench for conv_seq_ctrl against a frame-count /
// phase-level reference model of the sequencer.
module tb_conv_seq_ctrl;
  localparam int NCH = 8, WIN = 5, NOUT = 3, DW = 16, OW = 24;
  localparam int STRIDE = 2, CONV_LAT = 4;

  typedef logic [NCH-1:0][DW-1:0]  frame_t;
  typedef logic [NOUT-1:0][OW-1:0] res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.NCH(NCH), .WIN(WIN), .NOUT(NOUT), .DW(DW), .OW(OW)) bus ();

  conv_seq_ctrl #(.NCH(NCH), .WIN(WIN), .NOUT(NOUT), .DW(DW), .OW(OW),
                  .STRIDE(STRIDE), .CONV_LAT(CONV_LAT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: last WIN accepted frames, frames since flush, phase 0=fill 1=eval 2=hold.
  frame_t m_win[$];
  int     m_n, m_phase, m_cnt;
  bit     m_start;
  res_t   m_res;

  task automatic model_flush();
    m_win.delete();
    for (int i = 0; i < WIN; i++) m_win.push_back('0);
    m_n = 0; m_phase = 0; m_cnt = 0; m_start = 0; m_res = '0;
  endtask

  task automatic drive_frame(input frame_t f, input bit v);
    for (int c = 0; c < NCH; c++) bus.i_frame[c] = f[c];
    bus.i_frame_valid = v;
  endtask

  task automatic set_conv(input res_t r);
    for (int o = 0; o < NOUT; o++) bus.i_conv_out[o] = r[o];
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int c = 0; c < NCH; c++) f[c] = DW'($urandom);
    return f;
  endfunction

  function automatic res_t rand_res();
    res_t r;
    for (int o = 0; o < NOUT; o++) r[o] = OW'($urandom);
    return r;
  endfunction

  // One clock: snapshot inputs, advance the model at the edge, return #1 later.
  task automatic step();
    bit clr, rr, acc;
    frame_t fr;
    res_t cap;
    clr = bus.i_clear;
    rr  = bus.i_result_ready;
    acc = !clr && bus.i_frame_valid && (m_phase == 0);
    for (int c = 0; c < NCH; c++) fr[c] = bus.i_frame[c];
    for (int o = 0; o < NOUT; o++) cap[o] = bus.i_conv_out[o];
    @(posedge clk);
    m_start = 0;
    if (clr) model_flush();
    else case (m_phase)
      0: if (acc) begin
        m_win.push_back(fr);
        void'(m_win.pop_front());
        m_n++;
        if (m_n >= WIN && (m_n - WIN) % STRIDE == 0) begin
          m_phase = 1; m_cnt = CONV_LAT; m_start = 1;
        end
      end
      1: begin
        m_cnt--;
        if (m_cnt == 0) begin m_res = cap; m_phase = 2; end
      end
      default: if (rr) m_phase = 0;
    endcase
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    bus.i_clear = 1'b0; bus.i_result_ready = 1'b0;
    drive_frame('0, 1'b0);
    set_conv('0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_result_valid); end
    checks++; if (bus.o_conv_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.o_conv_start); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    bad = 0;
    for (int i = 0; i < NCH*WIN; i++) if (bus.o_conv_data[i] !== '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_conv_data: %0d nonzero words, want 0", bad); end
    rst_n = 1'b1;
    model_flush();
    step();
    checks++; if (bus.o_frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_frame_ready); end
  endtask

  task automatic test_fill_launch();
    frame_t f;
    res_t r;
    logic [DW-1:0] e;
    r[0] = 24'h000100; r[1] = 24'hFFFF00; r[2] = 24'h0008D8;
    set_conv(r);
    for (int t = 0; t < WIN; t++) begin
      for (int c = 0; c < NCH; c++) f[c] = DW'(16'h0100 * c + t);
      drive_frame(f, 1'b1);
      checks++; if (bus.o_frame_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", t, bus.o_frame_ready); end
      step();
      if (t < WIN-1) begin
        checks++; if (bus.o_conv_start !== 1'b0) begin errors++; $display("FAIL fill_early_start[%0d]: got %b want 0", t, bus.o_conv_start); end
      end
    end
    drive_frame('0, 1'b0);
    checks++; if (bus.o_conv_start !== 1'b1) begin errors++; $display("FAIL launch_start: got %b want 1", bus.o_conv_start); end
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < WIN; t++) begin
        e = DW'(16'h0100 * c + t);
        checks++;
        if (bus.o_conv_data[c*WIN+t] !== e) begin
          errors++; $display("FAIL launch_data[%0d]: got %h want %h", c*WIN+t, bus.o_conv_data[c*WIN+t], e);
        end
      end
    for (int k = 1; k <= CONV_LAT; k++) begin
      step();
      checks++; if (bus.o_frame_ready !== 1'b0) begin errors++; $display("FAIL run_ready[%0d]: got %b want 0", k, bus.o_frame_ready); end
      checks++; if (bus.o_conv_start !== 1'b0) begin errors++; $display("FAIL run_start[%0d]: got %b want 0", k, bus.o_conv_start); end
      checks++; if (bus.o_result_valid !== (k == CONV_LAT)) begin errors++; $display("FAIL run_valid[%0d]: got %b want %b", k, bus.o_result_valid, k == CONV_LAT); end
    end
    for (int o = 0; o < NOUT; o++) begin
      checks++; if (bus.o_result[o] !== r[o]) begin errors++; $display("FAIL launch_result[%0d]: got %h want %h", o, bus.o_result[o], r[o]); end
    end
  endtask

  task automatic test_backpressure();
    res_t hold;
    int xfers;
    for (int o = 0; o < NOUT; o++) hold[o] = bus.o_result[o];
    bus.i_result_ready = 1'b0;
    drive_frame(rand_frame(), 1'b1);
    set_conv(rand_res());
    repeat (10) begin
      step();
      checks++; if (bus.o_result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.o_result_valid); end
      checks++; if (bus.o_frame_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", bus.o_frame_ready); end
      for (int o = 0; o < NOUT; o++) begin
        checks++; if (bus.o_result[o] !== m_res[o]) begin errors++; $display("FAIL bp_result[%0d]: got %h want %h", o, bus.o_result[o], m_res[o]); end
      end
    end
    drive_frame('0, 1'b0);
    bus.i_result_ready = 1'b1;
    xfers = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.o_result_valid === 1'b1) xfers++;
      step();
      if (k == 0) begin
        checks++; if (bus.o_frame_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", bus.o_frame_ready); end
      end
    end
    bus.i_result_ready = 1'b0;
    checks++; if (xfers != 1) begin errors++; $display("FAIL bp_transfers: got %0d want 1", xfers); end
    for (int o = 0; o < NOUT; o++) begin
      checks++; if (bus.o_result[o] !== hold[o]) begin errors++; $display("FAIL bp_result_kept[%0d]: got %h want %h", o, bus.o_result[o], hold[o]); end
    end
  endtask

  task automatic test_stride();
    logic [DW-1:0] e;
    int bad;
    drive_frame(rand_frame(), 1'b1);
    step();
    drive_frame('0, 1'b0);
    checks++; if (bus.o_conv_start !== 1'b0) begin errors++; $display("FAIL stride_6th_start: got %b want 0", bus.o_conv_start); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL stride_6th_busy: got %b want 0", bus.o_busy); end
    drive_frame(rand_frame(), 1'b1);
    step();
    drive_frame('0, 1'b0);
    checks++; if (bus.o_conv_start !== 1'b1) begin errors++; $display("FAIL stride_7th_start: got %b want 1", bus.o_conv_start); end
    for (int c = 0; c < NCH; c++) begin
      e = DW'(16'h0100 * c + 2);
      checks++; if (bus.o_conv_data[c*WIN] !== e) begin errors++; $display("FAIL stride_oldest[%0d]: got %h want %h", c, bus.o_conv_data[c*WIN], e); end
    end
    bad = 0;
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < WIN; t++) if (bus.o_conv_data[c*WIN+t] !== m_win[t][c]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stride_window: %0d words differ from model", bad); end
    set_conv(rand_res());
    repeat (CONV_LAT) step();
    checks++; if (bus.o_result_valid !== 1'b1) begin errors++; $display("FAIL stride_valid: got %b want 1", bus.o_result_valid); end
    for (int o = 0; o < NOUT; o++) begin
      checks++; if (bus.o_result[o] !== m_res[o]) begin errors++; $display("FAIL stride_result[%0d]: got %h want %h", o, bus.o_result[o], m_res[o]); end
    end
    bus.i_result_ready = 1'b1;
    step();
    bus.i_result_ready = 1'b0;
  endtask

  task automatic test_clear_run();
    int bad;
    repeat (STRIDE) begin
      drive_frame(rand_frame(), 1'b1);
      step();
    end
    drive_frame(rand_frame(), 1'b1);
    checks++; if (bus.o_conv_start !== 1'b1) begin errors++; $display("FAIL clr_launch: got %b want 1", bus.o_conv_start); end
    repeat (2) step();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_frame_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", bus.o_frame_ready); end
    bad = 0;
    for (int i = 0; i < NCH*WIN; i++) if (bus.o_conv_data[i] !== '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_data: %0d nonzero words, want 0", bad); end
    drive_frame('0, 1'b0);
    for (int k = 0; k < CONV_LAT + 2; k++) begin
      checks++; if (bus.o_result_valid !== 1'b0) begin errors++; $display("FAIL clr_no_valid[%0d]: got %b want 0", k, bus.o_result_valid); end
      step();
    end
    for (int i = 0; i < WIN; i++) begin
      drive_frame(rand_frame(), 1'b1);
      step();
      checks++; if (bus.o_conv_start !== (i == WIN-1)) begin errors++; $display("FAIL clr_refill[%0d]: got %b want %b", i, bus.o_conv_start, i == WIN-1); end
    end
    drive_frame('0, 1'b0);
    repeat (CONV_LAT) step();
    bus.i_result_ready = 1'b1;
    step();
    bus.i_result_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_frame(rand_frame(), $urandom_range(0, 3) != 0);
      bus.i_result_ready = $urandom_range(0, 2) == 0;
      bus.i_clear = $urandom_range(0, 59) == 0;
      set_conv(rand_res());
      checks++; if (bus.o_frame_ready !== (m_phase == 0)) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, bus.o_frame_ready, m_phase == 0); end
      checks++; if (bus.o_result_valid !== (m_phase == 2)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus.o_result_valid, m_phase == 2); end
      checks++; if (bus.o_busy !== (m_phase != 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, bus.o_busy, m_phase != 0); end
      checks++; if (bus.o_conv_start !== m_start) begin errors++; $display("FAIL rnd_start@%0d: got %b want %b", cyc, bus.o_conv_start, m_start); end
      bad = 0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < WIN; t++) if (bus.o_conv_data[c*WIN+t] !== m_win[t][c]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd_window@%0d: %0d words differ from model", cyc, bad); end
      bad = 0;
      for (int o = 0; o < NOUT; o++) if (bus.o_result[o] !== m_res[o]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd_result@%0d: %0d words differ from model", cyc, bad); end
      step();
    end
    bus.i_clear = 1'b0;
    bus.i_result_ready = 1'b0;
    drive_frame('0, 1'b0);
  endtask

  task automatic test_async_reset();
    res_t r;
    int bad;
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    r[0] = 24'h123456; r[1] = 24'hABCDEF; r[2] = 24'h0F0F0F;
    set_conv(r);
    for (int i = 0; i < WIN; i++) begin
      drive_frame(rand_frame(), 1'b1);
      step();
    end
    drive_frame('0, 1'b0);
    repeat (CONV_LAT) step();
    checks++; if (bus.o_result_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", bus.o_result_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_result_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.o_result_valid); end
    bad = 0;
    for (int o = 0; o < NOUT; o++) if (bus.o_result[o] !== '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ar_result: %0d nonzero words, want 0", bad); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", bus.o_busy); end
    bad = 0;
    for (int i = 0; i < NCH*WIN; i++) if (bus.o_conv_data[i] !== '0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ar_data: %0d nonzero words, want 0", bad); end
    @(negedge clk);
    rst_n = 1'b1;
    model_flush();
    step();
    checks++; if (bus.o_frame_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", bus.o_frame_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_launch();
    test_backpressure();
    test_stride();
    test_clear_run();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer in front of the Conv datapath.
- Accepts a stream of sensor frames (NCH channels of Q8.8 samples), keeps a sliding window of WIN frames, and presents the window to Conv in Conv's channel-major layout.
- Launches an evaluation every STRIDE frames once the window is full, holds the window stable for CONV_LAT cycles, then captures Conv's NOUT results and hands them downstream over a valid/ready handshake.

Parameters:
- NCH, 8: channels per frame.
- WIN, 5: frames per window; Conv input count = NCH*WIN.
- NOUT, 3: Conv output count.
- DW, 16: sample width, signed Q8.8.
- OW, 24: result width, signed, as produced by Conv.
- STRIDE, 1: frames between launches after the first launch (>=1).
- CONV_LAT, 4: cycles from window-stable to Conv outputs valid (>=1).

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_clear, in, 1: synchronous flush of window and results.
- i_frame, in, NCH x DW (unpacked [0:NCH-1]): new frame, index = channel.
- i_frame_valid, in, 1: frame offered.
- o_frame_ready, out, 1: frame accepted when valid&ready at posedge.
- o_conv_data, out, NCH*WIN x DW ([0:NCH*WIN-1]): to Conv i_data; element ch*WIN+t, t=0 oldest.
- o_conv_start, out, 1: one-cycle pulse, first cycle of a new evaluation.
- i_conv_out, in, NOUT x OW ([0:NOUT-1]): from Conv o_weights.
- o_result, out, NOUT x OW: captured results.
- o_result_valid, out, 1: result available.
- i_result_ready, in, 1: downstream accepts result.
- o_busy, out, 1: state != FILL.

Behaviour:
- Reset (async, i_rst_n=0): state FILL; window, o_result, fill_cnt, stride_cnt, lat_cnt = 0; o_conv_start=0, o_result_valid=0. o_frame_ready=1 once reset is released.
- States:
  - FILL: o_frame_ready=1. Accepts frames.
  - RUN: o_frame_ready=0. Window frozen; lat_cnt counts.
  - OUT: o_frame_ready=0. o_result_valid=1.
- Frame accept (FILL, i_frame_valid=1):
  - Every channel shifts: word[ch*WIN+t] <= word[ch*WIN+t+1] for t<WIN-1, and word[ch*WIN+WIN-1] <= i_frame[ch].
  - fill_cnt saturates at WIN.
- Launch decision, evaluated on each accept:
  - If updated fill_cnt==WIN and no launch has occurred since the last reset/clear: launch.
  - Otherwise, if the window is already full, stride_cnt increments; a launch occurs when it reaches STRIDE, and stride_cnt then returns to 0.
  - No launch: stay in FILL.
- Launch at posedge k: state becomes RUN, lat_cnt=0, o_conv_start=1 for the cycle after k only. o_conv_data changes only on accepts, so it is stable throughout RUN and OUT.
- RUN: lat_cnt increments each cycle. When lat_cnt==CONV_LAT-1:
  - o_result <= i_conv_out;
  - state becomes OUT;
  - o_result_valid becomes 1, visible CONV_LAT cycles after o_conv_start first goes high.
- OUT: o_result and o_result_valid are held until i_result_ready=1 at a posedge. Then o_result_valid=0 and the state returns to FILL; o_frame_ready=1 the next cycle. o_result keeps its last value after the transfer.
- i_clear, highest synchronous priority in any state:
  - next state FILL; window, fill_cnt, stride_cnt, lat_cnt = 0;
  - o_result_valid=0, and any pending result is dropped;
  - o_conv_start=0;
  - a frame offered in the same cycle is not accepted.
- Async reset mid-RUN/OUT: every output is at its reset value immediately. No partial result survives.
- Data is not transformed: no arithmetic on samples or results, so widths pass through unchanged.

Test Plan:
1. Reset: i_rst_n=0 for 2 cycles.
   - Required: o_result_valid=0, o_conv_start=0, o_busy=0, all o_conv_data=0.
   - Required: o_frame_ready=1 after release.
2. Fill and launch: feed 5 frames (WIN=5, CONV_LAT=4) with i_frame[c] in frame t = 16'h0100*c+t.
   - Required: o_conv_start pulses the cycle after the 5th accept, with o_conv_data[c*5+t]=16'h0100*c+t.
   - Required: o_frame_ready=0 for the next 4 cycles.
   - Bench Conv model drives i_conv_out = {24'h000100, 24'hFFFF00, 24'h0008D8}. o_result_valid rises 4 cycles after o_conv_start and o_result matches.
3. Backpressure: hold i_result_ready=0 for 10 cycles.
   - Required: o_result_valid stays 1 and o_result is unchanged; o_frame_ready=0; a frame held on i_frame_valid is not accepted.
   - Raise ready: exactly one transfer occurs, then o_frame_ready=1 on the next cycle.
4. STRIDE=2 (after scenario 2): 6th frame accepted -> no launch, state FILL.
   - 7th frame -> launch, with o_conv_data holding frames 2..6 (t=0 is frame 2).
5. Clear during RUN: assert i_clear when lat_cnt=2.
   - Required: next cycle state FILL, o_busy=0, o_conv_data=0, and no o_result_valid.
   - Next launch occurs only after 5 new frames.
6. Async reset during OUT: drop i_rst_n between clock edges.
   - Required: o_result_valid=0 and o_result=0 immediately, without waiting for a clock edge.
